fft_bitrev_loader: RTL and testbench

Input stage of the FFT datapath, directly upstream of the first-stage butterfly. It collects one frame of N serial 16-bit samples into an internal buffer at bit-reversed addresses. It then streams the frame out as N/2 registered operand pairs (a, b) with a strobe (en) and a per-frame mode bit (ctrl), in the natural order the first-stage butterfly needs for decimation-in-time. One clock domain; no back-pressure from the butterfly.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_bitrev_index.sv | 16 +
 rtl/fft_bitrev_loader.sv | 127 ++++++++++++
 tb/tb_fft_bitrev_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT front-end constants, loader state encoding and bit-reversal helper.
package fft_pkg;

  localparam int unsigned FFT_W      = 16;
  localparam int unsigned FFT_N      = 8;
  localparam int unsigned FFT_LOGN   = 3;
  localparam int unsigned BITREV_MAX = 6;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Reverse the low logn bits of i; bits at and above logn come back as zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] i,
                                                   input int unsigned logn);
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < BITREV_MAX; k++) begin
      if (k < logn) r[k] = i[logn - 1 - k];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_index.sv
// Combinational LOGN-bit reversal of the loader write counter.
module fft_bitrev_index
  import fft_pkg::*;
#(
  parameter int unsigned LOGN = FFT_LOGN
) (
  input  logic [LOGN-1:0] idx_i,
  output logic [LOGN-1:0] rev_o
);

  logic [BITREV_MAX-1:0] rev_full;

  assign rev_full = bitrev(BITREV_MAX'(idx_i), LOGN);
  assign rev_o    = rev_full[LOGN-1:0];

endmodule

// File: rtl/fft_bitrev_loader.sv
// Collects one frame at bit-reversed addresses, then streams N/2 natural-order
// operand pairs to the first-stage DIT butterfly.
module fft_bitrev_loader
  import fft_pkg::*;
#(
  parameter  int unsigned N    = FFT_N,
  parameter  int unsigned W    = FFT_W,
  localparam int unsigned LOGN = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  output logic            in_ready,
  input  logic            inv,
  output logic [W-1:0]    a,
  output logic [W-1:0]    b,
  output logic            en,
  output logic            ctrl,
  output logic [LOGN-2:0] pair_idx,
  output logic            frame_done
);

  localparam int unsigned     PW      = LOGN - 1;
  localparam logic [LOGN-1:0] WR_LAST = LOGN'(N - 1);
  localparam logic [PW-1:0]   RD_LAST = PW'(N / 2 - 1);

  state_e          state_q, state_d;
  logic [LOGN-1:0] wr_cnt_q, wr_cnt_d, wr_addr;
  logic [PW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [PW-1:0]   pair_idx_q, pair_idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            en_q, en_d, ctrl_q, ctrl_d, fd_q, fd_d;
  logic [W-1:0]    mem [N];
  logic            accept, last_wr, last_rd;

  assign in_ready = (state_q == FILL);
  assign accept   = in_valid && in_ready;
  assign last_wr  = accept && (wr_cnt_q == WR_LAST);
  assign last_rd  = (state_q == DRAIN) && (rd_cnt_q == RD_LAST);

  fft_bitrev_index #(.LOGN(LOGN)) u_bitrev_index (
    .idx_i (wr_cnt_q),
    .rev_o (wr_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (last_wr) state_d = DRAIN;
      DRAIN:   if (last_rd) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Counters and the registered butterfly interface.
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    pair_idx_d = pair_idx_q;
    ctrl_d     = ctrl_q;
    en_d       = 1'b0;
    fd_d       = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          wr_cnt_d = last_wr ? '0 : wr_cnt_q + 1'b1;
          if (last_wr) begin
            ctrl_d   = inv;
            rd_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        a_d        = mem[{rd_cnt_q, 1'b0}];
        b_d        = mem[{rd_cnt_q, 1'b1}];
        pair_idx_d = rd_cnt_q;
        en_d       = 1'b1;
        fd_d       = last_rd;
        rd_cnt_d   = last_rd ? '0 : rd_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      pair_idx_q <= '0;
      en_q       <= 1'b0;
      ctrl_q     <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pair_idx_q <= pair_idx_d;
      en_q       <= en_d;
      ctrl_q     <= ctrl_d;
      fd_q       <= fd_d;
    end
  end

  // Sample buffer: no reset, contents are only meaningful once a frame completes.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= in_data;
  end

  assign a          = a_q;
  assign b          = b_q;
  assign pair_idx   = pair_idx_q;
  assign en         = en_q;
  assign ctrl       = ctrl_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Self-checking bench for fft_bitrev_loader (N=8) against a bit-reversal frame model.
module tb_fft_bitrev_loader;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        inv = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, en, ctrl, frame_done;
  logic [15:0] a, b;
  logic [1:0]  pair_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  idx;
    logic        ctrl;
    logic        fd;
    logic        rdy;
    logic [31:0] cyc;
  } pair_t;

  pair_t obs_q[$];
  pair_t exp_q[$];

  fft_bitrev_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .inv        (inv),
    .a          (a),
    .b          (b),
    .en         (en),
    .ctrl       (ctrl),
    .pair_idx   (pair_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en === 1'b1) obs_q.push_back({a, b, pair_idx, ctrl, frame_done, in_ready, 32'(cyc)});
  end

  function automatic int brev3(input int i);
    int r = 0;
    for (int k = 0; k < 3; k++) if ((i >> k) & 1) r = r | (1 << (2 - k));
    return r;
  endfunction

  // Pair k of a frame holds the samples whose bit-reversed indices are 2k and 2k+1;
  // it is visible in the cycle after edge e0+k+1 and in_ready rises on the last one.
  task automatic build_expect(input logic [15:0] s [N], input logic iv, input int e0);
    for (int k = 0; k < N / 2; k++) begin
      exp_q.push_back({s[brev3(2 * k)], s[brev3(2 * k + 1)], 2'(k), iv,
                       1'(k == N / 2 - 1), 1'(k == N / 2 - 1), 32'(e0 + k + 1)});
    end
  endtask

  // Entered and left at a negedge; mode 0 = dense, 1 = alternate gaps, 2 = random gaps.
  task automatic send_frame(input logic [15:0] s [N], input int mode, input logic iv,
                            output int e0, output int first_edge);
    int  i = 0;
    int  g = 0;
    logic v;
    e0 = -1;
    first_edge = -1;
    while (i < N && g < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'((g % 2) == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? s[i] : 16'($urandom);
      inv      = v ? iv : 1'($urandom);
      if (v && in_ready === 1'b1) begin
        if (i == 0) first_edge = cyc + 1;
        if (i == N - 1) e0 = cyc + 1;
        i++;
      end
      g++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (i < N) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout accepted %0d samples, required %0d", i, N);
    end
  endtask

  task automatic wait_pairs(input int n);
    int g = 0;
    while (obs_q.size() < n && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'($urandom);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({en, frame_done, a, b, ctrl, in_ready, pair_idx} !== {1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 2'b0}) begin
      n_fail++;
      $display("FAIL reset_state got en=%b fd=%b a=%h b=%h ctrl=%b rdy=%b idx=%0d required 0 0 0000 0000 0 1 0",
               en, frame_done, a, b, ctrl, in_ready, pair_idx);
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame(input string name, input int mode);
    logic [15:0] s [N];
    int e0, f;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < N; i++) s[i] = 16'(i);
    send_frame(s, mode, 1'b0, e0, f);
    build_expect(s, 1'b0, e0);
    wait_pairs(N / 2);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count got %0d pairs required %0d", name, obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL %s_pair%0d got %h required %h", name, k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s1 [N];
    logic [15:0] s2 [N];
    int e0a, e0b, fa, fb, g;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      s1[i] = 16'(i);
      s2[i] = 16'(16'h0010 + i);
    end
    send_frame(s1, 0, 1'b0, e0a, fa);
    g = 0;
    while (frame_done !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready got %b required 1 on last-pair cycle", in_ready);
    end
    send_frame(s2, 0, 1'b1, e0b, fb);
    n_checks++;
    if (fb != e0a + N / 2 + 1) begin
      n_fail++;
      $display("FAIL b2b_first_accept got edge %0d required %0d", fb, e0a + N / 2 + 1);
    end
    build_expect(s1, 1'b0, e0a);
    build_expect(s2, 1'b1, e0b);
    wait_pairs(N);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count got %0d pairs required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL b2b_pair%0d got %h required %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] s [N];
    int e0, f;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0B00 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) s[i] = 16'(16'h0C00 + i);
    send_frame(s, 0, 1'b1, e0, f);
    build_expect(s, 1'b1, e0);
    wait_pairs(N / 2);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rstfill_count got %0d pairs required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL rstfill_pair%0d got %h required %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [15:0] s [N];
    int e0, f, g;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < N; i++) s[i] = 16'(16'h0040 + i);
    send_frame(s, 0, 1'b1, e0, f);
    g = 0;
    while (!(en === 1'b1 && pair_idx === 2'd1) && g < 50) begin
      @(negedge clk);
      g++;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++;
    if ({en, frame_done, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rstdrain_after got en=%b fd=%b rdy=%b required 0 0 1", en, frame_done, in_ready);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL rstdrain_dropped got %0d pairs required 2", obs_q.size());
    end
    obs_q.delete();
    for (int i = 0; i < N; i++) s[i] = 16'(16'h00A0 + i);
    send_frame(s, 2, 1'b0, e0, f);
    build_expect(s, 1'b0, e0);
    wait_pairs(N / 2);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rstdrain_count got %0d pairs required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL rstdrain_pair%0d got %h required %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random_frames(input string name, input int frames, input logic extremes);
    logic [15:0] s [N];
    logic [15:0] ext [N];
    logic iv;
    int e0, f;
    ext = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFE, 16'h0000, 16'h8001, 16'h7FFE};
    for (int fr = 0; fr < frames; fr++) begin
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < N; i++) s[i] = extremes ? ext[i] : 16'($urandom);
      iv = 1'($urandom);
      send_frame(s, int'($urandom_range(0, 2)), iv, e0, f);
      build_expect(s, iv, e0);
      wait_pairs(N / 2);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL %s%0d_count got %0d pairs required %0d", name, fr, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) if (k < obs_q.size()) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL %s%0d_pair%0d got %h required %h", name, fr, k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame("frame", 0);
    test_frame("gapped", 1);
    test_back_to_back();
    test_reset_mid_fill();
    test_reset_mid_drain();
    test_random_frames("extreme", 1, 1'b1);
    test_random_frames("random", 6, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
